// File: rtl/cmd_bus_pkg.sv
// Shared constants, command codes and FSM encoding for the register command bus master.
// The V_ISSUE/V_CAPTURE states exist only when CMD_WRITE_VERIFY_EN is defined.
package cmd_bus_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_e;

  localparam int CTR0_ADDR   = 0;
  localparam int CTR1_ADDR   = 4;
  localparam int CTR2_ADDR   = 8;
  localparam int STATE0_ADDR = 12;
  localparam int STATE1_ADDR = 16;
  localparam int STATE2_ADDR = 20;

  localparam logic [5:0] CTR_WR_MASK = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_RESP
`ifdef CMD_WRITE_VERIFY_EN
    ,
    ST_V_ISSUE,
    ST_V_CAPTURE
`endif
  } state_e;

endpackage

// File: rtl/cmd_addr_check.sv
// Combinational address screen: alignment/range legality and write-to-read-only detection.
module cmd_addr_check #(
  parameter int ADDR_W     = 6,
  parameter int NUM_SLV    = 3,
  parameter int STATE_BASE = 12
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              write,
  output logic              legal,
  output logic              ro_violation
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 * NUM_SLV - 1) * 4);
  localparam logic [ADDR_W-1:0] RO_ADDR   = ADDR_W'(STATE_BASE);

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    legal        = (addr[1:0] == 2'b00) && (addr <= LAST_ADDR);
    ro_violation = write && (addr >= RO_ADDR);
  end

endmodule

// File: rtl/cmd_bus_master.sv
// Register command bus initiator: one request in flight, screened locally, one response out.
// Optional write read-back verification is enabled by defining CMD_WRITE_VERIFY_EN.
module cmd_bus_master
  import cmd_bus_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32,
  parameter int NUM_SLV    = 3,
  parameter int STATE_BASE = 12
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic [1:0]        cmd_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_data_o,
  input  logic [DATA_W-1:0] cmd_data_i
);

  state_e state;
  logic   write_q;
  logic   legal;
  logic   ro_violation;

  cmd_addr_check #(
    .ADDR_W    (ADDR_W),
    .NUM_SLV   (NUM_SLV),
    .STATE_BASE(STATE_BASE)
  ) u_addr_check (
    .addr        (req_addr_i),
    .write       (req_write_i),
    .legal       (legal),
    .ro_violation(ro_violation)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= ST_IDLE;
      write_q     <= 1'b0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      cmd_o       <= CMD_IDLE;
      cmd_addr_o  <= '0;
      cmd_data_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready_o <= 1'b1;
          if (req_valid_i && req_ready_o) begin
            req_ready_o <= 1'b0;
            write_q     <= req_write_i;
            if (legal && !ro_violation) begin
              cmd_o      <= req_write_i ? CMD_WRITE : CMD_READ;
              cmd_addr_o <= req_addr_i;
              cmd_data_o <= req_write_i ? req_wdata_i : '0;
              state      <= ST_ISSUE;
            end else begin
              // Rejected requests never touch the bus.
              rsp_valid_o <= 1'b1;
              rsp_err_o   <= 1'b1;
              rsp_rdata_o <= '0;
              state       <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (write_q) begin
`ifdef CMD_WRITE_VERIFY_EN
            cmd_o <= CMD_READ;
            state <= ST_V_ISSUE;
`else
            cmd_o       <= CMD_IDLE;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            state       <= ST_RESP;
`endif
          end else begin
            cmd_o <= CMD_IDLE;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= 1'b0;
          rsp_rdata_o <= cmd_data_i;
          state       <= ST_RESP;
        end
`ifdef CMD_WRITE_VERIFY_EN
        ST_V_ISSUE: begin
          cmd_o <= CMD_IDLE;
          state <= ST_V_CAPTURE;
        end
        ST_V_CAPTURE: begin
          // Only the writable control bits take part in the comparison.
          rsp_valid_o <= 1'b1;
          rsp_err_o   <= (cmd_data_i[5:0] & CTR_WR_MASK) != (cmd_data_o[5:0] & CTR_WR_MASK);
          rsp_rdata_o <= cmd_data_i;
          state       <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            req_ready_o <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: begin
          cmd_o <= CMD_IDLE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_bus_master.sv
// Directed bench for cmd_bus_master with a registered-read responder model.
// Define CMD_WRITE_VERIFY_EN for both RTL and bench to exercise write verification.
module tb_cmd_bus_master;
  import cmd_bus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [5:0]  req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [1:0]  cmd_o;
  logic [5:0]  cmd_addr_o;
  logic [31:0] cmd_data_o;
  logic [31:0] cmd_data_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  cmd_bus_master dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .cmd_o      (cmd_o),
    .cmd_addr_o (cmd_addr_o),
    .cmd_data_o (cmd_data_o),
    .cmd_data_i (cmd_data_i)
  );

  // Scoreboard address screen.
  logic [5:0] sb_addr = '0;
  logic       sb_write = 1'b0;
  logic       sb_legal;
  logic       sb_ro;

  cmd_addr_check u_sb (
    .addr        (sb_addr),
    .write       (sb_write),
    .legal       (sb_legal),
    .ro_violation(sb_ro)
  );

  // Responder: registered read data, drives z when not returning data.
  logic [31:0] regs [0:15];
  logic [31:0] rd_q = '0;
  logic        rd_v = 1'b0;
  logic        stuck_bit0 = 1'b0;

  always @(posedge clk_i) begin
    if (cmd_o == CMD_WRITE)
      regs[cmd_addr_o[5:2]] <= {26'b0, cmd_data_o[5:0] & CTR_WR_MASK};
    if (cmd_o == CMD_READ) begin
      rd_q <= stuck_bit0 ? (regs[cmd_addr_o[5:2]] & ~32'h1) : regs[cmd_addr_o[5:2]];
      rd_v <= 1'b1;
    end else begin
      rd_v <= 1'b0;
    end
  end

  assign cmd_data_i = rd_v ? rd_q : 'z;

  task automatic send_req(input logic w, input logic [5:0] a, input logic [31:0] d);
    req_valid_i = 1'b1;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic release_rsp();
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1 rsp_ready_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (cmd_o !== 2'b00 || cmd_addr_o !== 6'd0 || cmd_data_o !== 32'd0)
      $display("FAIL reset_bus: cmd=%b addr=%0d data=%h expected 00/0/0", cmd_o, cmd_addr_o, cmd_data_o);
    else n_pass++;
    n_checks++; if (rsp_valid_o !== 1'b0 || rsp_rdata_o !== 32'd0 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0)
      $display("FAIL reset_rsp: v=%b rd=%h err=%b rdy=%b expected 0/0/0/0", rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
    else n_pass++;
    @(negedge clk_i);
    rstn_i = 1'b1;
    @(negedge clk_i);
    n_checks++; if (req_ready_o !== 1'b1)
      $display("FAIL reset_ready: got %b expected 1", req_ready_o);
    else n_pass++;
  endtask

  task automatic test_read();
    send_req(1'b0, 6'd0, 32'hDEAD_BEEF);
    n_checks++; if (cmd_o !== 2'b01 || cmd_addr_o !== 6'd0 || cmd_data_o !== 32'd0 || req_ready_o !== 1'b0)
      $display("FAIL read_issue: cmd=%b addr=%0d data=%h rdy=%b expected 01/0/0/0", cmd_o, cmd_addr_o, cmd_data_o, req_ready_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (cmd_o !== 2'b00 || rsp_valid_o !== 1'b0)
      $display("FAIL read_capture: cmd=%b v=%b expected 00/0", cmd_o, rsp_valid_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd7 || rsp_err_o !== 1'b0)
      $display("FAIL read_rsp: v=%b rd=%h err=%b expected 1/00000007/0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    else n_pass++;
    release_rsp();
    n_checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1)
      $display("FAIL read_done: v=%b rdy=%b expected 0/1", rsp_valid_o, req_ready_o);
    else n_pass++;
  endtask

  task automatic test_write();
    send_req(1'b1, 6'd4, 32'hFFFF_FF2D);
    n_checks++; if (cmd_o !== 2'b10 || cmd_addr_o !== 6'd4 || cmd_data_o !== 32'hFFFF_FF2D)
      $display("FAIL write_issue: cmd=%b addr=%0d data=%h expected 10/4/ffffff2d", cmd_o, cmd_addr_o, cmd_data_o);
    else n_pass++;
    @(negedge clk_i);
`ifdef CMD_WRITE_VERIFY_EN
    n_checks++; if (cmd_o !== 2'b01 || cmd_addr_o !== 6'd4 || rsp_valid_o !== 1'b0)
      $display("FAIL write_vissue: cmd=%b addr=%0d v=%b expected 01/4/0", cmd_o, cmd_addr_o, rsp_valid_o);
    else n_pass++;
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++; if (cmd_o !== 2'b00 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h2D || rsp_err_o !== 1'b0)
      $display("FAIL write_rsp: cmd=%b v=%b rd=%h err=%b expected 00/1/0000002d/0", cmd_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    else n_pass++;
`else
    n_checks++; if (cmd_o !== 2'b00 || rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd0 || rsp_err_o !== 1'b0)
      $display("FAIL write_rsp: cmd=%b v=%b rd=%h err=%b expected 00/1/0/0", cmd_o, rsp_valid_o, rsp_rdata_o, rsp_err_o);
    else n_pass++;
`endif
    release_rsp();
    send_req(1'b0, 6'd4, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h2D || rsp_err_o !== 1'b0)
      $display("FAIL write_readback: v=%b rd=%h err=%b expected 1/0000002d/0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    else n_pass++;
    release_rsp();
  endtask

  task automatic test_illegal();
    logic       w_tab [3] = '{1'b1, 1'b0, 1'b0};
    logic [5:0] a_tab [3] = '{6'd12, 6'd6, 6'd24};
    for (int i = 0; i < 3; i++) begin
      send_req(w_tab[i], a_tab[i], 32'h1234_5678);
      n_checks++; if (cmd_o !== 2'b00 || rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'd0)
        $display("FAIL illegal_%0d: cmd=%b v=%b err=%b rd=%h expected 00/1/1/0", a_tab[i], cmd_o, rsp_valid_o, rsp_err_o, rsp_rdata_o);
      else n_pass++;
      release_rsp();
    end
  endtask

  task automatic test_addr_screen();
    logic       w_tab  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [5:0] a_tab  [6] = '{6'd12, 6'd6, 6'd24, 6'd20, 6'd8, 6'd20};
    logic       lg_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ro_tab [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      sb_write = w_tab[i];
      sb_addr  = a_tab[i];
      #1;
      n_checks++; if (sb_legal !== lg_tab[i] || sb_ro !== ro_tab[i])
        $display("FAIL screen_w%0d_a%0d: legal=%b ro=%b expected %b/%b", w_tab[i], a_tab[i], sb_legal, sb_ro, lg_tab[i], ro_tab[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    send_req(1'b0, 6'd16, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd64 || rsp_err_o !== 1'b0 || req_ready_o !== 1'b0) begin
        $display("FAIL hold_cycle%0d: v=%b rd=%h err=%b rdy=%b expected 1/00000040/0/0", i, rsp_valid_o, rsp_rdata_o, rsp_err_o, req_ready_o);
        bad++;
      end
      @(negedge clk_i);
    end
    n_checks++; if (bad != 0) $display("FAIL hold_stable: %0d bad cycles, expected 0", bad);
    else n_pass++;
    release_rsp();
    n_checks++; if (req_ready_o !== 1'b1 || rsp_valid_o !== 1'b0)
      $display("FAIL hold_release: rdy=%b v=%b expected 1/0", req_ready_o, rsp_valid_o);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    send_req(1'b0, 6'd0, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b0;
    #1;
    n_checks++; if (cmd_o !== 2'b00 || cmd_addr_o !== 6'd0 || rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0 || rsp_rdata_o !== 32'd0)
      $display("FAIL midreset_outs: cmd=%b addr=%0d v=%b rdy=%b rd=%h expected all 0", cmd_o, cmd_addr_o, rsp_valid_o, req_ready_o, rsp_rdata_o);
    else n_pass++;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b0) seen++;
    end
    n_checks++; if (seen != 0 || req_ready_o !== 1'b1)
      $display("FAIL midreset_norsp: valid seen %0d cycles rdy=%b expected 0/1", seen, req_ready_o);
    else n_pass++;
    send_req(1'b0, 6'd0, 32'd0);
    @(negedge clk_i);
    @(negedge clk_i);
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'd7 || rsp_err_o !== 1'b0)
      $display("FAIL midreset_next: v=%b rd=%h err=%b expected 1/00000007/0", rsp_valid_o, rsp_rdata_o, rsp_err_o);
    else n_pass++;
    release_rsp();
  endtask

`ifdef CMD_WRITE_VERIFY_EN
  task automatic test_write_verify();
    stuck_bit0 = 1'b1;
    send_req(1'b1, 6'd0, 32'h3F);
    n_checks++; if (cmd_o !== 2'b10 || cmd_data_o !== 32'h3F)
      $display("FAIL verify_issue: cmd=%b data=%h expected 10/0000003f", cmd_o, cmd_data_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (cmd_o !== 2'b01 || cmd_addr_o !== 6'd0)
      $display("FAIL verify_read: cmd=%b addr=%0d expected 01/0", cmd_o, cmd_addr_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (rsp_valid_o !== 1'b0 || cmd_o !== 2'b00)
      $display("FAIL verify_early: v=%b cmd=%b expected 0/00", rsp_valid_o, cmd_o);
    else n_pass++;
    @(negedge clk_i);
    n_checks++; if (rsp_valid_o !== 1'b1 || rsp_err_o !== 1'b1 || rsp_rdata_o !== 32'h3E)
      $display("FAIL verify_rsp: v=%b err=%b rd=%h expected 1/1/0000003e", rsp_valid_o, rsp_err_o, rsp_rdata_o);
    else n_pass++;
    release_rsp();
    stuck_bit0 = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[0] = 32'd7;
    regs[3] = 32'h11;
    regs[4] = 32'd64;
    regs[5] = 32'h55;
    test_reset();
    test_read();
    test_write();
    test_illegal();
    test_addr_screen();
    test_backpressure();
    test_reset_mid();
`ifdef CMD_WRITE_VERIFY_EN
    test_write_verify();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
